uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// - Receive-side buffer that sits directly downstream of the UART receiver.
// - Captures each word the receiver strobes out and holds it in a circular FIFO.
// - Presents the words to the consumer over a valid/ready handshake, oldest first (first-word-fall-through).
// - Drives the receiver's "can receive next word" gate so that a word the receiver has already started can never be lost.
//
// PARAMETERS
// - WIDTH  8   data word width; must equal the receiver word width.
// - DEPTH  16  FIFO entries; power of two, >= 2.
//
// PORTS
// - clock           in   1                   single clock; all logic on posedge.
// - resetn          in   1                   asynchronous, active-low reset.
// - rx_data         in   WIDTH               word from the receiver; sampled only when rx_ready=1.
// - rx_ready        in   1                   one-cycle strobe: rx_data holds a complete word.
// - rx_can_receive  out  1                   to receiver: 1 = it may accept a new start bit.
// - out_data        out  WIDTH               oldest stored word; valid only while out_valid=1.
// - out_valid       out  1                   FIFO non-empty.
// - out_ready       in   1                   consumer accepts out_data this cycle.
// - count           out  $clog2(DEPTH)+1     number of stored words, 0..DEPTH.
// - overflow        out  1                   sticky: a word arrived while full and was dropped.
// - overflow_clear  in   1                   synchronous clear of overflow.
//
// BEHAVIOUR
// - Reset (async assert, sync use after deassert):
//   - write pointer, read pointer and count = 0; overflow = 0.
//   - out_valid = 0; rx_can_receive = 1; stored contents are don't-care.
//   - Reset mid-operation discards all words; out_valid drops immediately.
// - Handshake events:
//   - push = rx_ready; pop = out_valid & out_ready.
// - Storage:
//   - Register array mem[DEPTH] of WIDTH bits.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
// - Push (not full): mem[wr_ptr] <= rx_data; wr_ptr++.
// - Pop: rd_ptr++; out_data is mem[rd_ptr], combinational from registers.
// - Latency: a word strobed at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
// - count update:
//   - +1 on push only.
//   - -1 on pop only.
//   - unchanged on push and pop in the same cycle.
// - out_valid = (count != 0); full = (count == DEPTH).
// - rx_can_receive = (count < DEPTH-1), combinational from count.
//   - The receiver checks this gate only at a start bit, and at most one word is in flight.
//   - This headroom of one entry guarantees no drop when the receiver follows the gate.
// - Push while full and pop in the same cycle: both are accepted, count stays DEPTH, no overflow.
// - Push while full without pop:
//   - The word is dropped; pointers and count are unchanged.
//   - overflow <= 1 on the next edge.
// - Pop while empty: impossible, because out_valid=0; out_ready is ignored.
// - overflow_clear: overflow <= 0, but a drop in the same cycle wins (overflow stays 1).
// - out_data must remain stable while out_valid=1 and out_ready=0, even if pushes occur.
// - No state machine beyond the pointer/count registers.
// - All updates happen on posedge clock or negedge resetn only.
//
// TESTING
// - Reset, then push 0xA5 with out_ready=0:
//   - count=1 and out_valid=1 the next cycle; out_data=0xA5.
//   - rx_can_receive stays 1.
// - Push 0x01..0x10 (DEPTH=16), out_ready=0:
//   - rx_can_receive falls when count reaches 15; count=16; no overflow.
//   - Then pop all 16: the data comes out 0x01..0x10 in order, and count returns to 0.
// - Full FIFO, push 0xEE with out_ready=0:
//   - overflow=1 and count=16; 0xEE never appears.
//   - Pulse overflow_clear: overflow=0.
// - Full FIFO, push 0x55 and pop in the same cycle:
//   - Overflow stays 0 and count stays 16.
//   - 0x55 appears after the 15 remaining older words.
// - Continuous push/pop at 1 word/cycle for 40 words:
//   - Pointers wrap at least twice; output order is identical to input; count never exceeds 1.
// - Assert resetn=0 with count=7 mid-stream:
//   - out_valid=0 immediately; count=0; overflow=0; rx_can_receive=1.
//   - The first push after release is read out first.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and its consumer.
// First-word-fall-through output with a one-entry headroom gate back to the receiver.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [WIDTH-1:0]           rx_data,
   input  logic                       rx_ready,
   output logic                       rx_can_receive,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       overflow_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LP_HIGH = CW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full = (r_count == LP_FULL);
   assign w_pop  = out_valid & out_ready;
   // A full FIFO still accepts a word when a pop frees the slot this cycle.
   assign w_push = rx_ready & (~w_full | w_pop);
   assign w_drop = rx_ready & w_full & ~w_pop;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clear) begin
         r_overflow <= 1'b0;
      end
   end

   assign out_valid      = (r_count != '0);
   assign out_data       = r_mem[r_rd_ptr];
   assign count          = r_count;
   assign overflow       = r_overflow;
   // One slot of headroom covers the word already in flight at the receiver.
   assign rx_can_receive = (r_count < LP_HIGH);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus
// hand-written fill/overflow/wrap/reset sequences.
module tb_uart_rx_fifo;

   logic       clock;
   logic       resetn;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_can_receive;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] count;
   logic       overflow;
   logic       overflow_clear;

   int n_tests;
   int n_fail;

   uart_rx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .rx_can_receive (rx_can_receive),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count          (count),
      .overflow       (overflow),
      .overflow_clear (overflow_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       push;
      logic [7:0] data;
      logic       ordy;
      logic       clr;
      logic [4:0] e_count;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_can;
      logic       e_ovf;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic p, input logic [7:0] d,
                      input logic o, input logic c);
      rx_ready       = p;
      rx_data        = d;
      out_ready      = o;
      overflow_clear = c;
      @(posedge clock);
      #1;
      rx_ready       = 1'b0;
      out_ready      = 1'b0;
      overflow_clear = 1'b0;
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] e;
   int         maxc;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rx_ready = 0; rx_data = 0; out_ready = 0; overflow_clear = 0;

      //            push data  ordy clr cnt val data  can ovf
      vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b1, 1'b0};
      vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b1, 1'b0};
      vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1, 1'b0};
      vt[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 5'd1, 1'b1, 8'h22, 1'b1, 1'b0};
      vt[5] = '{1'b1, 8'h33, 1'b0, 1'b1, 5'd2, 1'b1, 8'h22, 1'b1, 1'b0};
      vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h33, 1'b1, 1'b0};
      vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0};

      resetn = 1'b0;
      #12;
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_can", rx_can_receive, 1);
      chk("rst_ovf", overflow, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         cyc(vt[i].push, vt[i].data, vt[i].ordy, vt[i].clr);
         chk($sformatf("v%0d_count", i), count, vt[i].e_count);
         chk($sformatf("v%0d_valid", i), out_valid, vt[i].e_valid);
         if (vt[i].e_valid)
            chk($sformatf("v%0d_data", i), out_data, vt[i].e_data);
         chk($sformatf("v%0d_can", i), rx_can_receive, vt[i].e_can);
         chk($sformatf("v%0d_ovf", i), overflow, vt[i].e_ovf);
      end

      // fill to full
      for (int k = 1; k <= 16; k++) begin
         cyc(1'b1, 8'(k), 1'b0, 1'b0);
         exp_q.push_back(8'(k));
         chk($sformatf("fill%0d_count", k), count, k);
         chk($sformatf("fill%0d_can", k), rx_can_receive, (k < 15) ? 1 : 0);
      end
      chk("fill_ovf", overflow, 0);
      chk("fill_head", out_data, 8'h01);

      // drop while full
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("drop_ovf", overflow, 1);
      chk("drop_count", count, 16);
      chk("drop_head", out_data, 8'h01);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", overflow, 0);

      // drop and clear together: drop wins
      cyc(1'b1, 8'hEF, 1'b0, 1'b0);
      cyc(1'b1, 8'hEF, 1'b0, 1'b1);
      chk("dropclr_ovf", overflow, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr2_ovf", overflow, 0);

      // push and pop while full
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h55);
      chk("fullpp_count", count, 16);
      chk("fullpp_ovf", overflow, 0);

      // drain
      for (int k = 0; k < 16; k++) begin
         e = exp_q.pop_front();
         chk($sformatf("drain%0d_valid", k), out_valid, 1);
         chk($sformatf("drain%0d_data", k), out_data, e);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_count", count, 0);
      chk("drain_valid", out_valid, 0);

      // streaming at one word per cycle
      maxc = 0;
      cyc(1'b1, 8'h40, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         chk($sformatf("st%0d_data", i), out_data, 8'(8'h40 + i - 1));
         if (int'(count) > maxc) maxc = int'(count);
         cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      end
      chk("st_last", out_data, 8'h67);
      chk("st_maxcount", maxc, 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("st_empty", count, 0);

      // reset mid-stream with overflow set and count 7
      for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", count, 7);
      chk("pre_rst_ovf", overflow, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_can", rx_can_receive, 1);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      cyc(1'b1, 8'h9C, 1'b0, 1'b0);
      cyc(1'b1, 8'h9D, 1'b0, 1'b0);
      chk("post_rst_count", count, 2);
      chk("post_rst_data", out_data, 8'h9C);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_data2", out_data, 8'h9D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
